prio_arbiter4: RTL and testbench

Four-requester bus arbiter built around the 4-to-2 priority-encode function. It grants one shared resource to at most one requester at a time, holds the grant while the owner keeps requesting, and enforces a maximum tenure with forced release. An optional rotating-priority mode can be compiled in for fairness. The block sits between four client request lines and the shared datapath; the datapath mux is steered by `gnt_id`.

---
 rtl/prio_arbiter4_if.sv | 25 ++
 rtl/prio_arbiter4.sv | 96 +++++++++
 tb/tb_prio_arbiter4.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/prio_arbiter4_if.sv
// Request/grant bundle between four clients and the arbiter.
// The arbiter takes the slave side; clients or benches take the master side.
interface prio_arbiter4_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  modport master (
    output req,
    input  gnt,
    input  gnt_id,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_id,
    output busy,
    output timeout
  );
endinterface

// File: rtl/prio_arbiter4.sv
// Four-requester arbiter with hold-while-requested grants, bounded tenure and a one-cycle gap
// between owners. Define ARB_ROUND_ROBIN_EN to rotate priority away from the previous owner.
module prio_arbiter4 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input logic              clk,
  input logic              rst,
  prio_arbiter4_if.slave   bus
);

  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

  state_e           state;
  logic [1:0]       owner;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       win;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] last_id;

  // Walk the order last_id-4 .. last_id-1; later hits overwrite, so last_id-1 ends up strongest.
  always_comb begin
    win = last_id;
    for (int i = 4; i >= 1; i--) begin
      if (bus.req[last_id - 2'(i)]) begin
        win = last_id - 2'(i);
      end
    end
  end
`else
  always_comb begin
    casez (bus.req)
      4'b1???: win = 2'd3;
      4'b01??: win = 2'd2;
      4'b001?: win = 2'd1;
      default: win = 2'd0;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      owner       <= 2'd0;
      cnt         <= '0;
      bus.gnt     <= 4'b0000;
      bus.gnt_id  <= 2'd0;
      bus.busy    <= 1'b0;
      bus.timeout <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_id     <= 2'd0;
`endif
    end else begin
      bus.timeout <= 1'b0;
      unique case (state)
        StIdle, StGap: begin
          if (bus.req != 4'b0000) begin
            state      <= StGrant;
            owner      <= win;
            cnt        <= '0;
            bus.gnt    <= 4'b0001 << win;
            bus.gnt_id <= win;
            bus.busy   <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            last_id    <= win;
`endif
          end else begin
            state <= StIdle;
          end
        end
        StGrant: begin
          if (!bus.req[owner]) begin
            state      <= StGap;
            bus.gnt    <= 4'b0000;
            bus.gnt_id <= 2'd0;
            bus.busy   <= 1'b0;
          end else if ((MAX_HOLD != 0) && (cnt == HoldLast)) begin
            state       <= StGap;
            bus.gnt     <= 4'b0000;
            bus.gnt_id  <= 2'd0;
            bus.busy    <= 1'b0;
            bus.timeout <= 1'b1;
          end else if (cnt != '1) begin
            // Saturates only when the limit is disabled.
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_prio_arbiter4.sv
// Self-checking bench for prio_arbiter4 (MAX_HOLD = 4) against a cycle-level reference model.
module tb_prio_arbiter4;

  localparam int MaxHold = 4;

  logic clk;
  logic rst;
  prio_arbiter4_if bus ();

  prio_arbiter4 #(
    .MAX_HOLD (MaxHold),
    .CNT_W    (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who owns the resource and how many grant cycles it has shown so far.
  int m_owner = -1;
  int m_held  = 0;
  bit m_to    = 1'b0;
  int m_last  = 0;

  function automatic int pick(input logic [3:0] r);
    int w;
    w = -1;
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (((m_last - k) % 4) + 4) % 4;
      if (w < 0 && r[idx]) w = idx;
    end
`else
    for (int k = 3; k >= 0; k--) begin
      if (w < 0 && r[k]) w = k;
    end
`endif
    return w;
  endfunction

  task automatic model_step(input bit r_rst, input logic [3:0] r);
    if (r_rst) begin
      m_owner = -1;
      m_held  = 0;
      m_to    = 1'b0;
      m_last  = 0;
    end else if (m_owner >= 0) begin
      m_to = 1'b0;
      if (!r[m_owner]) begin
        m_owner = -1;
      end else if (MaxHold != 0 && m_held == MaxHold) begin
        m_owner = -1;
        m_to    = 1'b1;
      end else begin
        m_held++;
      end
    end else begin
      m_to = 1'b0;
      if (r != 4'b0000) begin
        m_owner = pick(r);
        m_held  = 1;
        m_last  = m_owner;
      end
    end
  endtask

  function automatic logic [7:0] model_out();
    logic [3:0] g;
    logic [1:0] id;
    g  = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    id = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    return {g, id, (m_owner >= 0), m_to};
  endfunction

  function automatic logic [7:0] dut_out();
    return {bus.gnt, bus.gnt_id, bus.busy, bus.timeout};
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed {gnt,id,busy,to}=%b expected %b", tag, got, exp);
    end
  endtask

  // Apply inputs away from the active edge, clock once, then compare with the model.
  task automatic step(input bit r_rst, input logic [3:0] r, input string tag);
    @(negedge clk);
    rst     = r_rst;
    bus.req = r;
    @(posedge clk);
    model_step(r_rst, r);
    #1;
    chk(tag, dut_out(), model_out());
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] r;
    bit         rr;
    rst     = 1'b1;
    bus.req = 4'b1111;

    // Reset held with all requests pending: nothing may be granted.
    step(1'b1, 4'b1111, "reset0");
    chk("reset0_zero", dut_out(), 8'h00);
    step(1'b1, 4'b1111, "reset1");
    chk("reset1_zero", dut_out(), 8'h00);
    step(1'b0, 4'b1111, "first_grant");
    chk("first_grant_is3", dut_out(), 8'h8E);

    // Owner 3 releases, then priority picks among the remaining requesters.
    step(1'b0, 4'b0110, "rel3_gap");
    step(1'b0, 4'b0110, "grant_next");
    step(1'b0, 4'b0010, "rel_gap");
    step(1'b0, 4'b0010, "grant_1");
    step(1'b0, 4'b0000, "rel_1");
    step(1'b0, 4'b0000, "idle");

    // Continuous request from 0: exactly MaxHold grant cycles, then a timeout gap.
    for (int i = 0; i < MaxHold; i++) begin
      step(1'b0, 4'b0001, "hold0");
      chk("hold0_gnt", dut_out(), 8'h12);
    end
    step(1'b0, 4'b0001, "to_gap");
    chk("to_gap_pulse", dut_out(), 8'h01);
    step(1'b0, 4'b0001, "regrant0");
    chk("regrant0_gnt", dut_out(), 8'h12);

    // Higher request appears while 0 holds: no preemption.
    step(1'b0, 4'b1001, "nopre0");
    step(1'b0, 4'b1001, "nopre1");
    step(1'b0, 4'b1001, "nopre2");
    step(1'b0, 4'b1000, "nopre_rel");
    step(1'b0, 4'b1000, "nopre_next");

    // All requesting for a while: tenures, timeouts and (if compiled in) rotation.
    for (int i = 0; i < 16; i++) step(1'b0, 4'b1111, "all_req");

    // Reset in the middle of a grant: drop immediately, no timeout.
    step(1'b0, 4'b0000, "pre_rst_rel");
    step(1'b0, 4'b0000, "pre_rst_idle");
    step(1'b0, 4'b0100, "mid_grant");
    step(1'b0, 4'b0100, "mid_grant_hold");
    step(1'b1, 4'b0100, "mid_rst");
    chk("mid_rst_zero", dut_out(), 8'h00);
    step(1'b0, 4'b0100, "after_rst");

    // Randomized traffic with sticky requests and occasional reset.
    r = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      rr = ($urandom_range(0, 59) == 0);
      step(rr, r, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
